beta_instr_issuer: RTL
======================

Name: beta_instr_issuer

Overview:
- Producer end of the Beta instruction bus: accepts decoded instruction fields from a stimulus or sequencer source.
- Encodes each request into a 32-bit Beta instruction word, buffers it in a FIFO, and drives INSTR to the processor with a valid/ready handshake.
- Illegal opcode classes are rejected and counted, not issued.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- ERR_CNT_W, 8, width of the saturating illegal-request counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  issuer can accept; equals !full.
- req_opcode  input  6  opcode, bits [31:26].
- req_src1  input  5  source register 1.
- req_src2  input  5  source register 2 (register class only).
- req_dest  input  5  destination register.
- req_lit  input  16  literal (classes 01/11).
- flush  input  1  synchronous clear of FIFO.
- INSTR  output  32  instruction word to processor.
- INSTR_VALID  output  1  INSTR holds a real instruction.
- INSTR_READY  input  1  processor consumes INSTR this cycle.
- err_illegal  output  1  one-cycle pulse on rejected request.
- err_cnt  output  ERR_CNT_W  saturating count of rejected requests.
- level  output  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, RST=1): FIFO empty, level=0, INSTR_VALID=0, INSTR=0 (or NOP, see Optional Feature), err_illegal=0, err_cnt=0, req_ready=1 once RST deasserts.
- Accept: request accepted on a rising edge where req_valid && req_ready.
- Encoding, by req_opcode[5:4], combinational before the write:
  - 2'b10 (register): {op, src1[25:21], src2[20:16], dest[15:11], 11'b0}.
  - 2'b11 (literal): {op, src1[25:21], dest[20:16], lit[15:0]}.
  - 2'b01, op==6'h19 (store): {op, src1[25:21], dest[20:16], lit[15:0]}.
  - 2'b01, other (load/branch): {op, dest[25:21], src1[20:16], lit[15:0]}.
  - 2'b00: illegal. Accepted and dropped, never written; err_illegal pulses the cycle after acceptance; err_cnt increments and saturates at all-ones.
- Output side: INSTR/INSTR_VALID are registers reflecting the FIFO head. Pop on an edge where INSTR_VALID && INSTR_READY.
- Latency: with the FIFO empty, a legal request accepted at edge k gives INSTR_VALID=1 with the encoded word after edge k (1 cycle).
- INSTR stable while INSTR_VALID && !INSTR_READY.
- Full: req_ready=0, even if a pop happens the same cycle (no push-through when full).
- Empty with push and pop in the same cycle: cannot occur, since INSTR_VALID=0.
- Non-empty, non-full with push and pop in the same cycle: level unchanged, order preserved.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH.
- flush: on the next edge, FIFO is emptied and INSTR_VALID=0. A request presented the same cycle is discarded, not counted. err_cnt is unaffected.
- RST mid-transfer: everything is cleared immediately and pending words are lost.
- FIFO state machine: EMPTY → ACTIVE (push) → FULL (level==DEPTH) → ACTIVE (pop) → EMPTY (last pop); flush from any state → EMPTY.

Optional Feature:
- Macro BETA_ISSUE_NOP_FILL_EN.
- Defined: whenever INSTR_VALID=0 (including reset), INSTR is driven to NOP_INSTR = 32'hC3FF0000 (ADDC R31,R31,0). The processor sees a harmless instruction each idle cycle.
- Undefined: when idle, INSTR holds the last issued word, or 0 after reset.

Decomposition:
- my_pkg adds:
  - opcode class enum (CLS_ILLEGAL, CLS_MEM, CLS_REG, CLS_LIT);
  - OP_ST = 6'h19;
  - NOP_INSTR constant;
  - pure function encode_instr(opcode, src1, src2, dest, lit) returning 32 bits plus an illegal flag. This function is shared with the scoreboard.
- One sub-module: beta_issue_fifo (parameterized DEPTH×32, push/pop/flush, full/empty/level).

Test Plan:
- ADD: req op=6'h20, src1=1, src2=2, dest=3 → next cycle INSTR=32'h80221800, INSTR_VALID=1, level=1.
- ADDC: op=6'h30, src1=4, dest=5, lit=16'h00FF → INSTR=32'hC08500FF. LD: op=6'h18, dest=7, src1=8, lit=16'h0010 → 32'h60E80010.
- ST: op=6'h19, src1=2, dest=9, lit=16'h0004 → 32'h64490004. Illegal op=6'h05 → no push, err_illegal pulse, err_cnt=1.
- Backpressure: INSTR_READY=0, push 5 requests with DEPTH=4 → req_ready=0 after 4, level=4. Release READY → 4 words issued in order, one per cycle.
- Flush at level=3 with a simultaneous req → next cycle level=0, INSTR_VALID=0, request not issued.
- RST asserted mid-stream between edges → outputs clear immediately. With BETA_ISSUE_NOP_FILL_EN, INSTR=32'hC3FF0000 while idle.

Source files
------------

// File: rtl/beta_instr_issuer_pkg.sv
// Shared definitions for the Beta instruction issuer: opcode classes,
// well-known opcodes/instructions, FIFO states and the field encoder.
package beta_instr_issuer_pkg;

  localparam logic [5:0]  OP_ST     = 6'h19;
  // ADDC R31,R31,0 -- architecturally a no-op
  localparam logic [31:0] NOP_INSTR = 32'hC3FF0000;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'b00,
    CLS_MEM     = 2'b01,
    CLS_REG     = 2'b10,
    CLS_LIT     = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_FULL
  } fifo_state_e;

  typedef struct packed {
    logic        illegal;
    logic [31:0] word;
  } enc_t;

  // Packs decoded fields into a Beta instruction word; class 00 is illegal.
  function automatic enc_t encode_instr(input logic [5:0]  opcode,
                                        input logic [4:0]  src1,
                                        input logic [4:0]  src2,
                                        input logic [4:0]  dest,
                                        input logic [15:0] lit);
    enc_t r;
    r.illegal = 1'b0;
    r.word    = '0;
    case (op_class_e'(opcode[5:4]))
      CLS_REG: r.word = {opcode, src1, src2, dest, 11'b0};
      CLS_LIT: r.word = {opcode, src1, dest, lit};
      CLS_MEM: begin
        if (opcode == OP_ST) r.word = {opcode, src1, dest, lit};
        else                 r.word = {opcode, dest, src1, lit};
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/beta_instr_issuer_fifo.sv
// Instruction buffer: DEPTH x WIDTH FIFO with flush, occupancy and an
// EMPTY/ACTIVE/FULL state machine from which full/empty are decoded.
module beta_issue_fifo
  import beta_instr_issuer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  fifo_state_e      state, state_next;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
  logic [LVL_W-1:0] count, count_next;
  logic             wr_en, rd_en;

  assign full  = (state == ST_FULL);
  assign empty = (state == ST_EMPTY);
  assign level = count;
  assign head  = mem[rd_ptr];

  // State, pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Storage array; contents need no reset since reads are qualified by state
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Next-state logic; flush overrides any push/pop in the same cycle
  always_comb begin
    wr_en       = push && !full && !flush;
    rd_en       = pop && !empty && !flush;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    state_next  = state;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      state_next  = ST_EMPTY;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr_next = rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      count_next = count + LVL_W'(1);
      else if (!wr_en && rd_en) count_next = count - LVL_W'(1);
      case (state)
        ST_EMPTY:  if (wr_en) state_next = ST_ACTIVE;
        ST_ACTIVE: begin
          if (count_next == LVL_W'(DEPTH)) state_next = ST_FULL;
          else if (count_next == '0)       state_next = ST_EMPTY;
        end
        ST_FULL:   if (rd_en) state_next = ST_ACTIVE;
        default:   state_next = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/beta_instr_issuer.sv
// Beta instruction issuer: encodes requested fields into instruction words,
// buffers them and presents them on INSTR with a valid/ready handshake.
// Illegal-class requests are dropped and counted.
// Optional: define BETA_ISSUE_NOP_FILL_EN to drive NOP_INSTR on INSTR while
// idle; otherwise INSTR holds the last presented word (0 after reset).
module beta_instr_issuer
  import beta_instr_issuer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [5:0]                 req_opcode,
  input  logic [4:0]                 req_src1,
  input  logic [4:0]                 req_src2,
  input  logic [4:0]                 req_dest,
  input  logic [15:0]                req_lit,
  input  logic                       flush,
  output logic [31:0]                INSTR,
  output logic                       INSTR_VALID,
  input  logic                       INSTR_READY,
  output logic                       err_illegal,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  enc_t        enc;
  logic        accept, push, pop, reject;
  logic        full, empty;
  logic [31:0] head;

  // Encode the presented request
  always_comb begin
    enc    = encode_instr(req_opcode, req_src1, req_src2, req_dest, req_lit);
    accept = req_valid && req_ready;
    push   = accept && !enc.illegal && !flush;
    reject = accept && enc.illegal && !flush;
    pop    = INSTR_VALID && INSTR_READY && !flush;
  end

  assign req_ready   = !full;
  assign INSTR_VALID = !empty;

  beta_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (enc.word),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Rejected-request pulse and saturating counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_illegal <= 1'b0;
      err_cnt     <= '0;
    end else begin
      err_illegal <= reject;
      if (reject && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

`ifdef BETA_ISSUE_NOP_FILL_EN
  assign INSTR = INSTR_VALID ? head : NOP_INSTR;
`else
  logic [31:0] last_word;

  // Remember the word on INSTR so it persists once the FIFO drains
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              last_word <= '0;
    else if (INSTR_VALID) last_word <= head;
  end

  assign INSTR = INSTR_VALID ? head : last_word;
`endif

endmodule
